// File: rtl/nand_cmd_addr_sequencer.sv
// NAND command/address latch sequencer: optional CMD1, up to ADDR_CYCLES address
// cycles, optional CMD2, then an optional tWB + R/B# wait with timeout.
module nand_cmd_addr_sequencer #(
    parameter int IO_W        = 8,
    parameter int ADDR_CYCLES = 5,
    parameter int T_WP        = 2,
    parameter int T_WH        = 2,
    parameter int T_WB        = 4,
    parameter int TIMEOUT     = 4096
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        use_cmd1,
    input  logic [IO_W-1:0]             cmd1,
    input  logic [2:0]                  n_addr,
    input  logic [IO_W*ADDR_CYCLES-1:0] addr,
    input  logic                        use_cmd2,
    input  logic [IO_W-1:0]             cmd2,
    input  logic                        wait_rb,
    input  logic                        rb_n,
    output logic                        CE_n,
    output logic                        CLE,
    output logic                        ALE,
    output logic                        WE_n,
    output logic                        RE_n,
    output logic [IO_W-1:0]             io_out,
    output logic                        io_oe,
    output logic                        busy,
    output logic                        done,
    output logic                        timeout
);

    localparam int ADDR_W   = IO_W * ADDR_CYCLES;
    localparam int BUS_LEN  = T_WP + T_WH;
    localparam int BUS_CW   = $clog2(BUS_LEN);
    localparam int WAIT_MAX = (TIMEOUT > T_WB) ? TIMEOUT : T_WB;
    localparam int WAIT_CW  = $clog2(WAIT_MAX + 1);

    localparam logic [2:0]         MAX_ADDR = 3'(ADDR_CYCLES);
    localparam logic [BUS_CW-1:0]  BUS_LAST = BUS_CW'(BUS_LEN - 1);
    localparam logic [BUS_CW-1:0]  WP_END   = BUS_CW'(T_WP);
    localparam logic [WAIT_CW-1:0] TWB_LAST = WAIT_CW'(T_WB - 1);
    localparam logic [WAIT_CW-1:0] TO_LAST  = WAIT_CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD1,
        S_ADDR,
        S_CMD2,
        S_WAIT_TWB,
        S_WAIT_RB,
        S_FINISH
    } state_t;

    state_t state, state_d;

    logic [BUS_CW-1:0]  bus_cnt;
    logic [WAIT_CW-1:0] wait_cnt;
    logic [2:0]         addr_left;
    logic               timed_out;

    logic               rb_q;
    logic               use_cmd2_q;
    logic               wait_rb_q;
    logic [IO_W-1:0]    cmd1_q;
    logic [IO_W-1:0]    cmd2_q;
    logic [ADDR_W-1:0]  addr_sh;

    logic [2:0]         n_addr_c;
    logic               bus_end;
    logic               we_high;
    logic               in_bus;
    logic               in_wait;

    // First enabled phase in CMD1 -> ADDR -> CMD2 -> WAIT_TWB -> FINISH order.
    function automatic state_t pick(input logic c1, input logic a, input logic c2, input logic w);
        if (c1)      return S_CMD1;
        else if (a)  return S_ADDR;
        else if (c2) return S_CMD2;
        else if (w)  return S_WAIT_TWB;
        else         return S_FINISH;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path infers a latch.
        state_d  = state;
        CE_n     = 1'b1;
        CLE      = 1'b0;
        ALE      = 1'b0;
        WE_n     = 1'b1;
        RE_n     = 1'b1;
        io_out   = '0;
        io_oe    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        timeout  = 1'b0;
        n_addr_c = (n_addr > MAX_ADDR) ? MAX_ADDR : n_addr;
        bus_end  = (bus_cnt == BUS_LAST);
        we_high  = (bus_cnt >= WP_END);
        in_bus   = (state == S_CMD1) || (state == S_ADDR) || (state == S_CMD2);
        in_wait  = (state == S_WAIT_TWB) || (state == S_WAIT_RB);

        if (in_bus || in_wait) begin
            CE_n = 1'b0;
            busy = 1'b1;
        end
        if (in_bus) begin
            WE_n  = we_high;
            io_oe = 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (start) state_d = pick(use_cmd1, n_addr_c != 3'd0, use_cmd2, wait_rb);
            end
            S_CMD1: begin
                CLE    = 1'b1;
                io_out = cmd1_q;
                if (bus_end) state_d = pick(1'b0, addr_left != 3'd0, use_cmd2_q, wait_rb_q);
            end
            S_ADDR: begin
                ALE    = 1'b1;
                io_out = addr_sh[IO_W-1:0];
                if (bus_end && addr_left == 3'd1) state_d = pick(1'b0, 1'b0, use_cmd2_q, wait_rb_q);
            end
            S_CMD2: begin
                CLE    = 1'b1;
                io_out = cmd2_q;
                if (bus_end) state_d = pick(1'b0, 1'b0, 1'b0, wait_rb_q);
            end
            S_WAIT_TWB: begin
                if (wait_cnt == TWB_LAST) state_d = S_WAIT_RB;
            end
            S_WAIT_RB: begin
                if (rb_q || wait_cnt == TO_LAST) state_d = S_FINISH;
            end
            S_FINISH: begin
                done    = 1'b1;
                timeout = timed_out;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_cnt   <= '0;
            wait_cnt  <= '0;
            addr_left <= '0;
            timed_out <= 1'b0;
        end else begin
            if (in_bus && !bus_end) bus_cnt <= bus_cnt + BUS_CW'(1);
            else                    bus_cnt <= '0;

            // Restarts from zero whenever a wait state is entered or left.
            if (in_wait && state_d == state) wait_cnt <= wait_cnt + WAIT_CW'(1);
            else                             wait_cnt <= '0;

            if (state == S_IDLE && start)       addr_left <= n_addr_c;
            else if (state == S_ADDR && bus_end) addr_left <= addr_left - 3'd1;

            if (state == S_WAIT_RB && !rb_q && wait_cnt == TO_LAST) timed_out <= 1'b1;
            else if (state == S_IDLE)                               timed_out <= 1'b0;
        end
    end

    // NOTE: request/data registers carry no reset; they are only read after a start loads them.
    always_ff @(posedge clk) begin
        rb_q <= rb_n;
        if (state == S_IDLE && start) begin
            use_cmd2_q <= use_cmd2;
            wait_rb_q  <= wait_rb;
            cmd1_q     <= cmd1;
            cmd2_q     <= cmd2;
            addr_sh    <= addr;
        end else if (state == S_ADDR && bus_end) begin
            addr_sh <= addr_sh >> IO_W;
        end
    end

endmodule

// File: tb/tb_nand_cmd_addr_sequencer.sv
// Directed, table-driven bench for nand_cmd_addr_sequencer with hand sequences
// for R/B# wait, timeout, busy-start and mid-sequence reset.
module tb_nand_cmd_addr_sequencer;

    localparam int IO_W = 8;
    localparam int ADDR_CYCLES = 5;
    localparam int T_WP = 2;
    localparam int T_WH = 2;
    localparam int T_WB = 4;
    localparam int TIMEOUT = 4096;

    logic        clk = 1'b0;
    logic        rst, start, use_cmd1, use_cmd2, wait_rb, rb_n;
    logic [7:0]  cmd1, cmd2;
    logic [2:0]  n_addr;
    logic [39:0] addr;
    logic        CE_n, CLE, ALE, WE_n, RE_n, io_oe, busy, done, timeout;
    logic [7:0]  io_out;

    always #5 clk = ~clk;

    nand_cmd_addr_sequencer #(
        .IO_W(IO_W), .ADDR_CYCLES(ADDR_CYCLES), .T_WP(T_WP), .T_WH(T_WH),
        .T_WB(T_WB), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .use_cmd1(use_cmd1), .cmd1(cmd1),
        .n_addr(n_addr), .addr(addr), .use_cmd2(use_cmd2), .cmd2(cmd2),
        .wait_rb(wait_rb), .rb_n(rb_n), .CE_n(CE_n), .CLE(CLE), .ALE(ALE),
        .WE_n(WE_n), .RE_n(RE_n), .io_out(io_out), .io_oe(io_oe), .busy(busy),
        .done(done), .timeout(timeout)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    localparam logic [16:0] IDLE_OUTS = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

    function automatic logic [16:0] outs();
        return {CE_n, CLE, ALE, WE_n, RE_n, io_oe, busy, done, timeout, io_out};
    endfunction

    // Every-clock protocol watch: CLE/ALE exclusive, RE_n high, bus stable and driven while WE_n low.
    int         viol = 0;
    int         n_done_seen = 0;
    logic [7:0] prev_io = 8'h00;
    logic       prev_we = 1'b1;
    always @(negedge clk) begin
        viol <= viol + int'(CLE && ALE) + int'(RE_n !== 1'b1)
                     + int'(!WE_n && !prev_we && io_out !== prev_io)
                     + int'(!WE_n && !io_oe);
        n_done_seen <= n_done_seen + int'(done === 1'b1);
        prev_we <= WE_n;
        prev_io <= io_out;
    end

    typedef struct {
        logic        c1;
        logic [7:0]  cmd1;
        logic [2:0]  na;
        logic [39:0] addr;
        logic        c2;
        logic [7:0]  cmd2;
        int          n_bus;
        int          done_cyc;
        logic [63:0] bytes;
        int          ale;
        int          cle;
    } vec_t;

    int          r_done, r_nbus, r_we_low, r_ce_low, r_ale, r_cle, r_rise;
    logic [63:0] r_bytes;
    logic        r_to, r_busy_done, r_ce_done, r_done_after, r_to_after, r_busy_after, r_ce_after;

    // Called #1 after a rising edge; returns #1 after a rising edge with DUT idle.
    task automatic run(input vec_t v, input logic wrb, input int rb_rise, input int budget,
                       input logic restart);
        int   cyc;
        logic pw;
        use_cmd1 = v.c1; cmd1 = v.cmd1; n_addr = v.na; addr = v.addr;
        use_cmd2 = v.c2; cmd2 = v.cmd2; wait_rb = wrb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        use_cmd1 = ~v.c1; cmd1 = ~v.cmd1; n_addr = ~v.na; addr = ~v.addr;
        use_cmd2 = ~v.c2; cmd2 = ~v.cmd2; wait_rb = ~wrb;
        r_done = -1; r_nbus = 0; r_we_low = 0; r_ce_low = 0; r_ale = 0; r_cle = 0;
        r_rise = -1; r_bytes = '0; r_to = 1'bx; r_busy_done = 1'bx; r_ce_done = 1'bx;
        cyc = 0; pw = 1'b1;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (!WE_n && pw && r_nbus < 8) begin
                r_bytes = r_bytes | (64'(io_out) << (8 * r_nbus));
                r_nbus++;
            end
            pw = WE_n;
            if (!WE_n) r_we_low++;
            if (!CE_n) r_ce_low++;
            if (ALE)   r_ale++;
            if (CLE)   r_cle++;
            if (done) begin
                r_done = cyc; r_to = timeout; r_busy_done = busy; r_ce_done = CE_n;
                if (restart) begin
                    use_cmd1 = 1'b1; cmd1 = 8'hAA; n_addr = 3'd2; use_cmd2 = 1'b1;
                    wait_rb = 1'b0; start = 1'b1;
                end
                break;
            end
            if (cyc == rb_rise) begin
                rb_n = 1'b1;
                r_rise = cyc;
            end
        end
        @(negedge clk);
        r_done_after = done; r_to_after = timeout; r_busy_after = busy; r_ce_after = CE_n;
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    vec_t vecs[7];
    vec_t v;
    int   n0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 8'h00, 3'd5, 40'h04_03_02_01_00, 1'b1, 8'h30, 7, 29, 64'h30_04_03_02_01_00_00, 20, 8};
        vecs[1] = '{1'b0, 8'h00, 3'd7, 40'hEE_DD_CC_BB_AA, 1'b0, 8'h00, 5, 21, 64'hEE_DD_CC_BB_AA, 20, 0};
        vecs[2] = '{1'b0, 8'h00, 3'd0, 40'h00_00_00_00_00, 1'b0, 8'h00, 0, 1, 64'h0, 0, 0};
        vecs[3] = '{1'b1, 8'hFF, 3'd0, 40'h00_00_00_00_12, 1'b0, 8'h00, 1, 5, 64'hFF, 0, 4};
        vecs[4] = '{1'b0, 8'h00, 3'd2, 40'h99_88_77_5A_A5, 1'b1, 8'hE0, 3, 13, 64'hE0_5A_A5, 8, 4};
        vecs[5] = '{1'b1, 8'h05, 3'd1, 40'h11_22_33_44_77, 1'b0, 8'h00, 2, 9, 64'h77_05, 4, 4};
        vecs[6] = '{1'b1, 8'h80, 3'd6, 40'h55_44_33_22_11, 1'b1, 8'h10, 7, 29, 64'h10_55_44_33_22_11_80, 20, 8};

        rst = 1'b1; start = 1'b0; use_cmd1 = 1'b0; use_cmd2 = 1'b0; wait_rb = 1'b0;
        rb_n = 1'b1; cmd1 = '0; cmd2 = '0; n_addr = '0; addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'(outs()), 64'(IDLE_OUTS));
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_outputs", 64'(outs()), 64'(IDLE_OUTS));

        for (int i = 0; i < 7; i++) begin
            run(vecs[i], 1'b0, -1, 100, 1'b0);
            check($sformatf("v%0d_done_cycle", i), 64'(r_done), 64'(vecs[i].done_cyc));
            check($sformatf("v%0d_bus_cycles", i), 64'(r_nbus), 64'(vecs[i].n_bus));
            check($sformatf("v%0d_io_bytes", i), r_bytes, vecs[i].bytes);
            check($sformatf("v%0d_we_low", i), 64'(r_we_low), 64'(vecs[i].n_bus * T_WP));
            check($sformatf("v%0d_ce_low", i), 64'(r_ce_low), 64'(vecs[i].n_bus * (T_WP + T_WH)));
            check($sformatf("v%0d_ale_clocks", i), 64'(r_ale), 64'(vecs[i].ale));
            check($sformatf("v%0d_cle_clocks", i), 64'(r_cle), 64'(vecs[i].cle));
            check($sformatf("v%0d_finish_flags", i), {61'b0, r_to, r_busy_done, r_ce_done}, 64'b001);
            check($sformatf("v%0d_done_single", i), 64'(r_done_after), 64'd0);
        end

        // Erase with R/B# low ~50 clocks.
        v = '{1'b1, 8'h60, 3'd3, 40'h00_00_03_02_01, 1'b1, 8'hD0, 5, 0, 64'hD0_03_02_01_60, 12, 8};
        rb_n = 1'b0;
        run(v, 1'b1, 50, 200, 1'b0);
        check("erase_io_bytes", r_bytes, v.bytes);
        check("erase_we_low", 64'(r_we_low), 64'(5 * T_WP));
        check("erase_rb_latency_ok", 64'(r_rise > 0 && r_done > r_rise && r_done - r_rise <= 2), 64'd1);
        check("erase_timeout", 64'(r_to), 64'd0);

        // R/B# stuck low: FINISH at 1 + N*(T_WP+T_WH) + T_WB + TIMEOUT.
        v = '{1'b1, 8'h10, 3'd0, 40'h0, 1'b0, 8'h00, 1, 0, 64'h10, 0, 4};
        rb_n = 1'b0;
        run(v, 1'b1, -1, 6000, 1'b0);
        check("stuck_done_cycle", 64'(r_done), 64'(1 + 1 * (T_WP + T_WH) + T_WB + TIMEOUT));
        check("stuck_timeout", 64'(r_to), 64'd1);
        check("stuck_pulse_end", {62'b0, r_done_after, r_to_after}, 64'd0);
        rb_n = 1'b1;

        // Start during FINISH is ignored.
        run(vecs[3], 1'b0, -1, 100, 1'b1);
        check("finish_start_done", 64'(r_done), 64'd5);
        check("finish_start_ignored", {62'b0, r_busy_after, r_ce_after}, 64'b01);

        // Start while busy is ignored, then reset mid-ADDR aborts with no done.
        n0 = n_done_seen;
        use_cmd1 = 1'b1; cmd1 = 8'h00; n_addr = 3'd5; addr = 40'h04_03_02_01_00;
        use_cmd2 = 1'b1; cmd2 = 8'h30; wait_rb = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        use_cmd1 = 1'b1; cmd1 = 8'hAA; n_addr = 3'd0; use_cmd2 = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_start_addr0", {54'b0, ALE, CLE, io_out}, {54'b0, 1'b1, 1'b0, 8'h00});
        repeat (3) @(negedge clk);
        check("busy_start_addr1", {54'b0, ALE, CLE, io_out}, {54'b0, 1'b1, 1'b0, 8'h01});
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midseq_reset_outputs", 64'(outs()), 64'(IDLE_OUTS));
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("midseq_reset_no_done", 64'(n_done_seen - n0), 64'd0);
        check("midseq_reset_idle", 64'(outs()), 64'(IDLE_OUTS));

        @(negedge clk);
        check("protocol_violations", 64'(viol), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
